// File: rtl/fp32_to_int32.sv
// fp32_to_int32: converts an IEEE-754 single to a signed 32-bit integer,
// truncating toward zero. In-range operands are aligned by a right shifter
// that moves at most 8 bit positions per cycle. Zero, sub-one and
// out-of-range operands are resolved directly on the accept edge.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | ready for an operand (o_ready=1)
// SHIFT | aligning the mantissa, up to 8 bit positions per cycle
// OUT   | result presented (o_valid=1) until i_ready
module fp32_to_int32 (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_data,
  output logic        o_inexact,
  output logic        o_invalid
);

  typedef enum logic [1:0] {IDLE, SHIFT, OUT} state_t;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] r;
  logic [4:0]  d;
  logic        sticky;
  logic        sgn;

  logic        in_s;
  logic [7:0]  in_e;
  logic [22:0] in_f;
  logic        in_nan;
  logic        in_shift;

  logic [31:0] special_data;
  logic        special_inexact;
  logic        special_invalid;

  logic [3:0]  k;
  logic [31:0] r_sh;
  logic        lost;
  logic        last;
  logic [4:0]  d_nxt;

  assign in_s     = i_data[31];
  assign in_e     = i_data[30:23];
  assign in_f     = i_data[22:0];
  assign in_nan   = (in_e == 8'hFF) && (in_f != 23'd0);
  assign in_shift = (in_e >= 8'd127) && (in_e <= 8'd157);

  // Shift step: at most 8 positions, and exactly the remaining distance on the last step.
  assign k     = (d > 5'd8) ? 4'd8 : d[3:0];
  assign r_sh  = r >> k;
  assign lost  = |(r & ~(32'hFFFF_FFFF << k));
  assign last  = (d <= 5'd8);
  assign d_nxt = d - {1'b0, k};

  // Results for operands that never enter SHIFT.
  always_comb begin
    special_data    = 32'd0;
    special_inexact = 1'b0;
    special_invalid = 1'b0;
    if (in_e == 8'd0) begin
      special_inexact = (in_f != 23'd0);
    end else if (in_e < 8'd127) begin
      special_inexact = 1'b1;
    end else if (i_data == 32'hCF00_0000) begin
      // exactly -2^31 is representable
      special_data = 32'h8000_0000;
    end else begin
      special_invalid = 1'b1;
      special_data    = (in_s && !in_nan) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_valid) state_nxt = in_shift ? SHIFT : OUT;
      SHIFT:   if (last)    state_nxt = OUT;
      OUT:     if (i_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    o_ready = (state == IDLE);
    o_valid = (state == OUT);
  end

  // Datapath: operand capture, iterative alignment and result registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r         <= 32'd0;
      d         <= 5'd0;
      sticky    <= 1'b0;
      sgn       <= 1'b0;
      o_data    <= 32'd0;
      o_inexact <= 1'b0;
      o_invalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            sgn    <= in_s;
            sticky <= 1'b0;
            if (in_shift) begin
              r <= {1'b1, in_f, 8'h00};
              // 158 - e, computed mod 32: 158 = 30 (mod 32) and the result is 1..31
              d <= 5'd30 - in_e[4:0];
            end else begin
              o_data    <= special_data;
              o_inexact <= special_inexact;
              o_invalid <= special_invalid;
            end
          end
        end
        SHIFT: begin
          r      <= r_sh;
          d      <= d_nxt;
          sticky <= sticky | lost;
          if (last) begin
            o_data    <= sgn ? (~r_sh + 32'd1) : r_sh;
            o_inexact <= sticky | lost;
            o_invalid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
